// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding and
// the iteration-counter width helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // Counter counts WIDTH-1 down to 0, which always fits in $clog2(WIDTH) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One radix-2 restoring division step on magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the result if non-negative.
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // rem_in < divisor_mag always holds, so the shifted value needs one extra
    // bit only transiently and the kept remainder fits back in WIDTH bits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {1'b0, divisor_mag};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: sign-magnitude operands, one restoring quotient
// bit per clock, start/busy/done handshake, truncating quotient.
module seq_signed_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] quotient,
    output logic signed [WIDTH-1:0] remainder,
    output logic                    div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_p0;
    logic [WIDTH-1:0] dvd_p0;
    logic [WIDTH-1:0] dvs_p0;
    logic             sign_q_p0;
    logic             sign_r_p0;
    logic             dz_p0;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             accept;

    // Most-negative input wraps to itself, which reads as 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                           input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    assign accept = (state == ST_IDLE) && start;

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in      (rem_p0),
        .dvd_bit     (dvd_p0[WIDTH-1]),
        .divisor_mag (dvs_p0),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (divisor == '0) ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Operand capture and iteration datapath; the dividend register doubles
    // as the quotient shift register, and holds the raw dividend on divide-by-zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q_p0 <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_p0 <= dividend[WIDTH-1];
            dz_p0     <= (divisor == '0);
            rem_p0    <= '0;
            dvd_p0    <= (divisor == '0) ? WIDTH'(dividend) : abs_mag(dividend);
            dvs_p0    <= abs_mag(divisor);
        end else if (state == ST_CALC) begin
            rem_p0 <= step_rem;
            dvd_p0 <= {dvd_p0[WIDTH-2:0], step_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(WIDTH - 1);
        end else if (state == ST_CALC) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Result registers: written once in FIX, held until the next operation completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            div_by_zero <= 1'b0;
        end else if (state == ST_FIX) begin
            if (dz_p0) begin
                quotient    <= '1;
                remainder   <= $signed(dvd_p0);
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= apply_sign(dvd_p0, sign_q_p0);
                remainder   <= apply_sign(rem_p0, sign_r_p0);
            end
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed-vector bench for seq_signed_divider (WIDTH=32).
module tb_seq_signed_divider;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [31:0] dividend;
    logic signed [31:0] divisor;
    logic               busy;
    logic               done;
    logic signed [31:0] quotient;
    logic signed [31:0] remainder;
    logic               div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. poke = cycle index at which a
    // stray 50/5 start is asserted for one cycle (0 = none).
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input int elat, input int poke);
        int lat;
        int busy_err;
        int dz_early;
        lat      = 0;
        busy_err = 0;
        dz_early = 0;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'h1234_5678;
        divisor  = 32'h0000_0001;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            if (!busy) busy_err++;
            if (k == 1 && div_by_zero) dz_early++;
            if (done) lat = k;
            if (k == poke) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_busy_run"}, 32'(busy_err), 32'd0);
        chk({tag, "_dz_cleared"}, 32'(dz_early), 32'd0);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_no_requeue"}, 32'(busy), 32'd0);
        chk({tag, "_q_hold"}, quotient, eq);
    endtask

    int done_seen;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("p100_7",   32'd100,        32'd7,          32'd14,        32'd2,         1'b0, 34, 0);
        run_div("n100_7",   -32'sd100,      32'd7,          32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 0);
        run_div("p100_n7",  32'd100,        -32'sd7,        32'hFFFF_FFF2, 32'd2,         1'b0, 34, 0);
        run_div("n100_n7",  -32'sd100,      -32'sd7,        32'd14,        32'hFFFF_FFFE, 1'b0, 34, 0);
        run_div("min_n1",   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0, 34, 0);
        run_div("min_2",    32'h8000_0000,  32'd2,          32'hC000_0000, 32'd0,         1'b0, 34, 0);
        run_div("zero_5",   32'd0,          32'd5,          32'd0,         32'd0,         1'b0, 34, 0);
        run_div("n3_7",     -32'sd3,        32'd7,          32'd0,         32'hFFFF_FFFD, 1'b0, 34, 0);
        run_div("div0",     32'd5,          32'd0,          32'hFFFF_FFFF, 32'd5,         1'b1, 2,  0);
        run_div("after_dz", 32'd9,          32'd3,          32'd3,         32'd0,         1'b0, 34, 0);
        run_div("ign_calc", 32'd100,        32'd7,          32'd14,        32'd2,         1'b0, 34, 5);
        run_div("ign_done", 32'd100,        32'd7,          32'd14,        32'd2,         1'b0, 34, 34);

        // Abort mid-calculation with a synchronous reset.
        done_seen = 0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        if (done) done_seen++;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk("abort_dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        run_div("p7_7", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 34, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
Sequential signed integer divider: the inverse of the team's combinational signed array multiplier, sharing its sign-magnitude scheme (absolute-value operands, unsigned core, sign correction on output). Radix-2 restoring division, one quotient bit per clock, start/busy/done handshake. Used by datapath blocks needing A/B and A%B without a combinational divider's area.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>=4)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; accepted only when busy=0
dividend  input  WIDTH  signed dividend, sampled on accepted start
divisor  input  WIDTH  signed divisor, sampled on accepted start
busy  output  1  high from cycle after accepted start until done cycle, inclusive
done  output  1  single-cycle pulse; results valid from this cycle
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, sign follows dividend
div_by_zero  output  1  set with done when divisor==0

Behaviour:
- Interface: one clock (clk); rst_n synchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Reset mid-operation aborts: no done pulse, outputs cleared next edge.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 at edge t -> capture operands; store sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB]; load |dividend|, |divisor| (two's-complement negate when MSB set; most-negative value maps to unsigned 2^(WIDTH-1)); clear partial remainder (WIDTH+1 bits); iteration counter=WIDTH-1. If divisor==0 -> FIX, else -> CALC.
- CALC: per cycle shift {rem, dvd} left by 1; trial = rem - |divisor| (WIDTH+1 bits); trial non-negative -> rem=trial, quotient bit=1, else bit=0. Exactly WIDTH cycles, then -> FIX.
- FIX: quotient = sign_q ? -q_mag : q_mag; remainder = sign_r ? -r_mag : r_mag (both truncated to WIDTH). Divide-by-zero: quotient = all ones, remainder = dividend as given, div_by_zero=1. -> DONE.
- DONE: done=1 for this cycle only; busy=1; -> IDLE.
- Latency: start accepted at edge t -> done high in cycle t+WIDTH+2 (normal), t+2 (divide-by-zero).
- Outputs hold last result until next accepted start; div_by_zero clears on next accepted start.
- start while busy=1 (including DONE cycle): ignored, operands not sampled, no queueing.
- Overflow: most-negative / -1 -> quotient = most-negative (wraps), remainder=0, div_by_zero=0; no separate flag.
- Dividend 0 / nonzero divisor: normal path, quotient=0, remainder=0.
- Identity: for divisor!=0, quotient*divisor + remainder == dividend (mod 2^WIDTH), |remainder| < |divisor|.

Decomposition:
- Package seq_divider_pkg: state encoding constants (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3), counter-width helper ($clog2(WIDTH)).
- One sub-module: restoring_div_step (combinational, parameter WIDTH): inputs partial remainder, next dividend bit, |divisor|; outputs new remainder and quotient bit. Instantiated once inside CALC datapath.

Test Plan:
- 100 / 7, start at t -> done at t+34; quotient=14, remainder=2, div_by_zero=0, busy high t+1..t+34.
- -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2; 100 / -7 -> quotient=-14, remainder=2; -100 / -7 -> quotient=14, remainder=-2.
- -2147483648 / -1 -> quotient=0x80000000, remainder=0; -2147483648 / 2 -> quotient=-1073741824, remainder=0.
- 5 / 0 -> done at t+2, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5; next 9/3 -> div_by_zero=0, quotient=3, remainder=0.
- start pulsed with 50/5 while busy on 100/7 -> ignored; result 14/2 only; one done pulse.
- rst_n low at CALC cycle 10 -> next edge all outputs 0, busy=0, no done; new start 7/7 -> quotient=1, remainder=0.
